// File: rtl/bin_to_bcd_digits.sv
// bin_to_bcd_digits: sequential binary-to-BCD converter (shift-add-3 / double dabble).
// A start pulse in IDLE captures bin_in. The conversion then runs one shift step per
// cycle for BIN_WIDTH cycles, and the result is latched in FINISH. The latched digits
// stay stable until the next conversion finishes. One nibble is muxed out per digit_sel.
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   start, bin_in   conversion request and binary value (sampled only in IDLE)
//   busy            high while shifting
//   done            one-cycle pulse in FINISH
//   overflow        last value exceeded 10^NUM_DIGITS-1 (result saturated to all 9s)
//   bcd_out         latched BCD result, nibble 0 = least significant digit
//   digit_sel/digit combinational digit select; out-of-range index returns 4'hF
module bin_to_bcd_digits #(
    parameter int unsigned BIN_WIDTH  = 16,
    parameter int unsigned NUM_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    bin_in,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    input  logic [2:0]              digit_sel,
    output logic [3:0]              digit
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam longint unsigned MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state_q;
    logic [BIN_WIDTH-1:0] shift_q;
    logic [BCD_W-1:0]     scratch_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ovf_pend_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 overflow_q;
    logic [BCD_W-1:0]     bcd_out_q;

    logic [BCD_W-1:0]     adj_d;
    logic [BCD_W-1:0]     scratch_d;
    logic [BIN_WIDTH-1:0] shift_d;

    // One double-dabble step: add 3 to every nibble >= 5 (no inter-nibble carry), then shift.
    always_comb begin
        adj_d = scratch_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (scratch_q[i*4 +: 4] >= 4'd5) begin
                adj_d[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
            end
        end
        // The truncating cast discards the bit shifted out of the top of the scratch.
        scratch_d = BCD_W'({adj_d, shift_q[BIN_WIDTH-1]});
        shift_d   = shift_q << 1;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_out_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shift_q    <= bin_in;
                        scratch_q  <= '0;
                        cnt_q      <= CNT_W'(BIN_WIDTH);
                        ovf_pend_q <= (64'(bin_in) > MAX_VAL);
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    shift_q   <= shift_d;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    // Last step: busy drops and done rises for the FINISH cycle.
                    if (cnt_q == CNT_W'(1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    bcd_out_q  <= ovf_pend_q ? {NUM_DIGITS{4'h9}} : scratch_q;
                    overflow_q <= ovf_pend_q;
                    done_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Digit mux; indices beyond NUM_DIGITS return 4'hF so that column is blanked.
    always_comb begin
        digit = 4'hF;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit_sel == 3'(i)) begin
                digit = bcd_out_q[i*4 +: 4];
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign bcd_out  = bcd_out_q;

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Directed and randomized bench for bin_to_bcd_digits. Two instances share the stimulus:
// the default 5-digit configuration and a 4-digit configuration that exercises saturation.
module tb_bin_to_bcd_digits;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bin_in;
    logic [2:0]  digit_sel;

    logic        busy5, done5, ovf5;
    logic [19:0] bcd5;
    logic [3:0]  digit5;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;
    logic [3:0]  digit4;

    int tests;
    int fails;

    bin_to_bcd_digits #(.BIN_WIDTH(16), .NUM_DIGITS(5)) u_dut5 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin_in    (bin_in),
        .busy      (busy5),
        .done      (done5),
        .overflow  (ovf5),
        .bcd_out   (bcd5),
        .digit_sel (digit_sel),
        .digit     (digit5)
    );

    bin_to_bcd_digits #(.BIN_WIDTH(16), .NUM_DIGITS(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin_in    (bin_in),
        .busy      (busy4),
        .done      (done4),
        .overflow  (ovf4),
        .bcd_out   (bcd4),
        .digit_sel (digit_sel),
        .digit     (digit4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal reference: digit i is (v / 10^i) % 10.
    function automatic logic [31:0] to_bcd(input int unsigned v, input int unsigned nd);
        logic [31:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int unsigned i = 0; i < nd; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Start a conversion on both instances and check latency, pulse width and results.
    task automatic convert(input logic [15:0] v, input logic [19:0] exp5,
                           input logic [15:0] exp4, input logic exp_ovf4);
        int lat;
        bin_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        lat    = 1;
        check("busy_after_start", 64'(busy5), 64'd1);
        while (!done5 && lat < 40) begin
            tick();
            lat++;
        end
        check("done_latency", 64'(lat), 64'd17);
        check("busy_in_finish", 64'(busy5), 64'd0);
        check("done4_aligned", 64'(done4), 64'd1);
        tick();
        check("done_one_cycle", 64'(done5), 64'd0);
        check("bcd5", 64'(bcd5), 64'(exp5));
        check("ovf5", 64'(ovf5), 64'd0);
        check("bcd4", 64'(bcd4), 64'(exp4));
        check("ovf4", 64'(ovf4), 64'(exp_ovf4));
    endtask

    initial begin
        logic [31:0] ref5;
        logic [31:0] ref4;
        logic [3:0]  sweep [8];
        int          ndone;
        int unsigned rv;

        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        start     = 1'b0;
        bin_in    = '0;
        digit_sel = 3'd0;
        tick();
        tick();
        tick();
        check("rst_busy", 64'(busy5), 64'd0);
        check("rst_done", 64'(done5), 64'd0);
        check("rst_ovf", 64'(ovf5), 64'd0);
        check("rst_bcd", 64'(bcd5), 64'd0);
        check("rst_digit0", 64'(digit5), 64'd0);
        reset = 1'b0;
        tick();

        // Basic conversion and digit taps.
        convert(16'd12345, 20'h12345, 16'h9999, 1'b1);
        digit_sel = 3'd0;
        #1 check("digit_sel0", 64'(digit5), 64'h5);
        digit_sel = 3'd4;
        #1 check("digit_sel4", 64'(digit5), 64'h1);

        // Full select sweep, including out-of-range indices.
        sweep = '{4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'hF, 4'hF, 4'hF};
        for (int i = 0; i < 8; i++) begin
            digit_sel = 3'(i);
            #1 check($sformatf("sweep%0d", i), 64'(digit5), 64'(sweep[i]));
        end
        digit_sel = 3'd4;
        #1 check("digit4_oob", 64'(digit4), 64'hF);

        // Result holds while idle.
        repeat (30) tick();
        check("hold_bcd", 64'(bcd5), 64'h12345);

        // Boundaries and 4-digit saturation.
        convert(16'd0, 20'h00000, 16'h0000, 1'b0);
        convert(16'd65535, 20'h65535, 16'h9999, 1'b1);
        convert(16'd10000, 20'h10000, 16'h9999, 1'b1);
        convert(16'd9999, 20'h09999, 16'h9999, 1'b0);

        // A start while busy is ignored.
        tick();
        bin_in = 16'd100;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (4) tick();
        bin_in = 16'd999;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        ndone  = 0;
        for (int i = 0; i < 40; i++) begin
            if (done5) ndone++;
            tick();
        end
        check("busy_start_one_done", 64'(ndone), 64'd1);
        check("busy_start_bcd", 64'(bcd5), 64'h00100);

        // Reset in the middle of a conversion aborts it.
        bin_in = 16'd4321;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 64'(busy5), 64'd0);
        check("abort_bcd", 64'(bcd5), 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done5) ndone++;
            tick();
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        convert(16'd4321, 20'h04321, 16'h4321, 1'b0);

        // Reset wins over a simultaneous start.
        reset  = 1'b1;
        start  = 1'b1;
        bin_in = 16'd77;
        tick();
        reset  = 1'b0;
        start  = 1'b0;
        check("reset_wins_busy", 64'(busy5), 64'd0);
        tick();
        check("reset_wins_idle", 64'(busy5), 64'd0);

        // Random values against the decimal reference.
        for (int n = 0; n < 1000; n++) begin
            rv   = $urandom_range(65535, 0);
            ref5 = to_bcd(rv, 5);
            ref4 = to_bcd(rv, 4);
            if (rv > 9999) ref4 = 32'h9999;
            convert(16'(rv), ref5[19:0], ref4[15:0], rv > 9999);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
